// File: rtl/data_mem_ctrl.sv
// Parametrised data memory: four byte lanes, sub-word stores, extended registered loads,
// fault strobes and a post-reset clear sequencer that zeroes every word.

module dm_lane #(
    parameter int AW = 6
) (
    input  logic          clk_dm,
    input  logic          we,
    input  logic [AW-1:0] addr,
    input  logic [7:0]    wdata,
    output logic [7:0]    rdata
);
    logic [7:0] mem [2**AW];

    always_ff @(posedge clk_dm) begin
        if (we) mem[addr] <= wdata;
    end

    // Read and write never share a cycle, so one shared address is enough.
    assign rdata = mem[addr];
endmodule

module data_mem_ctrl #(
    parameter int BYTE_ADDR_W = 8
) (
    input  logic                   clk_dm,
    input  logic                   rst,
    input  logic                   Mem_Read,
    input  logic                   Mem_Write,
    input  logic [2:0]             Mem_Funct3,
    input  logic [BYTE_ADDR_W-1:0] DM_Addr,
    input  logic [31:0]            M_W_Data,
    output logic [31:0]            M_R_Data,
    output logic                   M_R_Valid,
    output logic                   Mem_Busy,
    output logic                   Mem_Fault
);
    localparam int AW    = BYTE_ADDR_W - 2;
    localparam int WORDS = 2**AW;
    localparam logic [AW-1:0] LAST = AW'(WORDS - 1);

    typedef enum logic {CLEAR, IDLE} state_t;

    state_t          state, state_nxt;
    logic [AW-1:0]   clr_cnt;

    logic [AW-1:0]   word_idx;
    logic [1:0]      lane;
    logic            rd_req, wr_req, both_req;
    logic            ld_ok, st_ok, misalign, fault_now, st_go;
    logic [AW-1:0]   mem_addr;
    logic [3:0]      lane_we;
    logic [3:0][7:0] lane_wdata;
    logic [3:0][7:0] lane_rdata;
    logic [7:0]      ld_byte;
    logic [15:0]     ld_half;
    logic [31:0]     ld_ext;

    // ---------------- clear sequencer FSM ----------------
    always_ff @(posedge clk_dm) begin
        if (rst) begin
            state   <= CLEAR;
            clr_cnt <= '0;
        end else begin
            state <= state_nxt;
            if (state == CLEAR) clr_cnt <= clr_cnt + 1'b1;
        end
    end

    always_comb begin
        state_nxt = state;
        case (state)
            CLEAR:   if (clr_cnt == LAST) state_nxt = IDLE;
            IDLE:    state_nxt = IDLE;
            default: state_nxt = CLEAR;
        endcase
    end

    always_comb begin
        Mem_Busy = (state == CLEAR);
    end

    // ---------------- request decode ----------------
    assign word_idx = DM_Addr[BYTE_ADDR_W-1:2];
    assign lane     = DM_Addr[1:0];

    always_comb begin
        rd_req   = !Mem_Busy && Mem_Read && !Mem_Write;
        wr_req   = !Mem_Busy && Mem_Write && !Mem_Read;
        both_req = !Mem_Busy && Mem_Read && Mem_Write;
        ld_ok    = (Mem_Funct3 == 3'b000) || (Mem_Funct3 == 3'b001) || (Mem_Funct3 == 3'b010)
                || (Mem_Funct3 == 3'b100) || (Mem_Funct3 == 3'b101);
        st_ok    = (Mem_Funct3 == 3'b000) || (Mem_Funct3 == 3'b001) || (Mem_Funct3 == 3'b010);
        misalign = ((Mem_Funct3[1:0] == 2'b01) && lane[0])
                || ((Mem_Funct3[1:0] == 2'b10) && (lane != 2'b00));
        fault_now = both_req
                 || (rd_req && (!ld_ok || misalign))
                 || (wr_req && (!st_ok || misalign));
        st_go    = wr_req && st_ok && !misalign;
        mem_addr = Mem_Busy ? clr_cnt : word_idx;
    end

    // ---------------- byte lanes ----------------
    for (genvar i = 0; i < 4; i++) begin : g_lane
        logic sel;

        always_comb begin
            sel = 1'b0;
            case (Mem_Funct3[1:0])
                2'b00:   sel = (lane == 2'(i));
                2'b01:   sel = (lane[1] == 1'(i / 2));
                default: sel = 1'b1;
            endcase
            lane_we[i] = Mem_Busy || (st_go && sel);
            // Store data is replicated so every lane sees its slice regardless of offset.
            if (Mem_Busy)
                lane_wdata[i] = 8'h00;
            else if (Mem_Funct3[1:0] == 2'b00)
                lane_wdata[i] = M_W_Data[7:0];
            else if (Mem_Funct3[1:0] == 2'b01)
                lane_wdata[i] = M_W_Data[8*(i%2) +: 8];
            else
                lane_wdata[i] = M_W_Data[8*i +: 8];
        end

        dm_lane #(.AW(AW)) u_lane (
            .clk_dm (clk_dm),
            .we     (lane_we[i]),
            .addr   (mem_addr),
            .wdata  (lane_wdata[i]),
            .rdata  (lane_rdata[i])
        );
    end

    // ---------------- load extension ----------------
    always_comb begin
        ld_byte = lane_rdata[lane];
        ld_half = {lane_rdata[{lane[1], 1'b1}], lane_rdata[{lane[1], 1'b0}]};
        case (Mem_Funct3)
            3'b000:  ld_ext = {{24{ld_byte[7]}}, ld_byte};
            3'b001:  ld_ext = {{16{ld_half[15]}}, ld_half};
            3'b010:  ld_ext = lane_rdata;
            3'b100:  ld_ext = {24'h0, ld_byte};
            3'b101:  ld_ext = {16'h0, ld_half};
            default: ld_ext = 32'h0;
        endcase
    end

    always_ff @(posedge clk_dm) begin
        if (rst) begin
            M_R_Data  <= 32'h0;
            M_R_Valid <= 1'b0;
            Mem_Fault <= 1'b0;
        end else begin
            M_R_Valid <= rd_req;
            Mem_Fault <= fault_now;
            // A faulting load still completes, returning zero.
            if (rd_req) M_R_Data <= fault_now ? 32'h0 : ld_ext;
        end
    end
endmodule

// File: tb/tb_data_mem_ctrl.sv
// Directed bench for data_mem_ctrl: init timing, table of load/store/fault vectors,
// reset during clear and operation, and a small 8-word instance.

module tb_data_mem_ctrl;
    logic        clk_dm = 1'b0;
    logic        rst, rd, wr;
    logic [2:0]  f3;
    logic [7:0]  addr;
    logic [31:0] wd, rdata;
    logic        rvalid, busy, fault;

    logic        s_rst, s_rd, s_wr;
    logic [2:0]  s_f3;
    logic [4:0]  s_addr;
    logic [31:0] s_wd, s_rdata;
    logic        s_rvalid, s_busy, s_fault;

    int n_vec  = 0;
    int n_miss = 0;

    always #5 clk_dm = ~clk_dm;

    data_mem_ctrl dut (
        .clk_dm(clk_dm), .rst(rst), .Mem_Read(rd), .Mem_Write(wr), .Mem_Funct3(f3),
        .DM_Addr(addr), .M_W_Data(wd), .M_R_Data(rdata), .M_R_Valid(rvalid),
        .Mem_Busy(busy), .Mem_Fault(fault)
    );

    data_mem_ctrl #(.BYTE_ADDR_W(5)) dut_s (
        .clk_dm(clk_dm), .rst(s_rst), .Mem_Read(s_rd), .Mem_Write(s_wr), .Mem_Funct3(s_f3),
        .DM_Addr(s_addr), .M_W_Data(s_wd), .M_R_Data(s_rdata), .M_R_Valid(s_rvalid),
        .Mem_Busy(s_busy), .Mem_Fault(s_fault)
    );

    typedef struct {
        logic        rd, wr;
        logic [2:0]  f3;
        logic [7:0]  addr;
        logic [31:0] wd;
        logic        chk_d;
        logic [31:0] ed;
        logic        ev, ef;
    } vec_t;

    vec_t tbl[$];

    function automatic vec_t mk(logic r, logic w, logic [2:0] fn, logic [7:0] a, logic [31:0] d,
                                logic cd, logic [31:0] e, logic v, logic f);
        vec_t t;
        t.rd = r; t.wr = w; t.f3 = fn; t.addr = a; t.wd = d;
        t.chk_d = cd; t.ed = e; t.ev = v; t.ef = f;
        return t;
    endfunction

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_miss++;
            $display("FAIL %s: got %h expected %h", nm, act, exp);
        end
    endtask

    // Drive one request on the falling edge, return just after the sampling edge.
    task automatic step(input logic r, input logic w, input logic [2:0] fn,
                        input logic [7:0] a, input logic [31:0] d);
        @(negedge clk_dm);
        rd = r; wr = w; f3 = fn; addr = a; wd = d;
        @(posedge clk_dm);
        #1;
    endtask

    task automatic s_step(input logic r, input logic w, input logic [2:0] fn,
                          input logic [4:0] a, input logic [31:0] d);
        @(negedge clk_dm);
        s_rd = r; s_wr = w; s_f3 = fn; s_addr = a; s_wd = d;
        @(posedge clk_dm);
        #1;
    endtask

    // Counts edges until Mem_Busy drops; also counts any strobe seen while clearing.
    task automatic wait_idle(output int n, output int strobes);
        n = 0;
        strobes = 0;
        for (int k = 0; k < 200; k++) begin
            @(posedge clk_dm);
            #1;
            n++;
            if (rvalid || fault) strobes++;
            if (!busy) break;
        end
        rd = 1'b0; wr = 1'b0;
    endtask

    initial begin
        int n_m, n_s, strb;

        rst = 1'b1; rd = 0; wr = 0; f3 = 0; addr = 0; wd = 0;
        s_rst = 1'b1; s_rd = 0; s_wr = 0; s_f3 = 0; s_addr = 0; s_wd = 0;
        repeat (2) @(posedge clk_dm);
        #1;
        chk("reset M_R_Data", rdata, 32'h0);
        chk("reset M_R_Valid", {31'h0, rvalid}, 32'h0);
        chk("reset Mem_Fault", {31'h0, fault}, 32'h0);
        chk("reset Mem_Busy", {31'h0, busy}, 32'h1);
        chk("small reset Mem_Busy", {31'h0, s_busy}, 32'h1);

        // Release both instances together and time their clears.
        @(negedge clk_dm);
        rst = 1'b0; s_rst = 1'b0;
        n_m = 0; n_s = 0;
        for (int k = 1; k <= 200; k++) begin
            @(posedge clk_dm);
            #1;
            if (!s_busy && n_s == 0) n_s = k;
            if (!busy && n_m == 0) n_m = k;
            if (n_s != 0 && n_m != 0) break;
        end
        chk("busy edges 64 words", n_m, 64);
        chk("busy edges 8 words", n_s, 8);

        for (int w = 0; w < 64; w++) begin
            step(1, 0, 3'b010, 8'(w * 4), 32'h0);
            chk($sformatf("init LW %0d data", w), rdata, 32'h0);
            chk($sformatf("init LW %0d valid", w), {31'h0, rvalid}, 32'h1);
            step(0, 0, 3'b010, 8'h0, 32'h0);
            chk($sformatf("init idle %0d valid", w), {31'h0, rvalid}, 32'h0);
        end

        tbl.push_back(mk(0, 1, 3'b010, 8'h10, 32'h8000_00FF, 0, 0, 0, 0));
        tbl.push_back(mk(1, 0, 3'b000, 8'h10, 0, 1, 32'hFFFF_FFFF, 1, 0));
        tbl.push_back(mk(1, 0, 3'b100, 8'h10, 0, 1, 32'h0000_00FF, 1, 0));
        tbl.push_back(mk(1, 0, 3'b001, 8'h12, 0, 1, 32'hFFFF_8000, 1, 0));
        tbl.push_back(mk(1, 0, 3'b101, 8'h12, 0, 1, 32'h0000_8000, 1, 0));
        tbl.push_back(mk(0, 1, 3'b010, 8'h20, 32'h1122_3344, 0, 0, 0, 0));
        tbl.push_back(mk(0, 1, 3'b000, 8'h21, 32'hFFFF_FFAA, 0, 0, 0, 0));
        tbl.push_back(mk(0, 1, 3'b001, 8'h22, 32'h1234_BEEF, 0, 0, 0, 0));
        tbl.push_back(mk(1, 0, 3'b010, 8'h20, 0, 1, 32'hBEEF_AA44, 1, 0));
        tbl.push_back(mk(1, 0, 3'b000, 8'h21, 0, 1, 32'hFFFF_FFAA, 1, 0));
        tbl.push_back(mk(1, 0, 3'b100, 8'h23, 0, 1, 32'h0000_00BE, 1, 0));
        tbl.push_back(mk(1, 0, 3'b001, 8'h20, 0, 1, 32'hFFFF_AA44, 1, 0));
        tbl.push_back(mk(0, 1, 3'b010, 8'h06, 32'hDEAD_BEEF, 0, 0, 0, 1));
        tbl.push_back(mk(1, 0, 3'b010, 8'h04, 0, 1, 32'h0, 1, 0));
        tbl.push_back(mk(1, 0, 3'b001, 8'h03, 0, 1, 32'h0, 1, 1));
        tbl.push_back(mk(1, 0, 3'b010, 8'h22, 0, 1, 32'h0, 1, 1));
        tbl.push_back(mk(1, 0, 3'b011, 8'h20, 0, 1, 32'h0, 1, 1));
        tbl.push_back(mk(0, 1, 3'b100, 8'h20, 32'h0, 0, 0, 0, 1));
        tbl.push_back(mk(1, 1, 3'b010, 8'h20, 32'h5555_5555, 0, 0, 0, 1));
        tbl.push_back(mk(1, 0, 3'b010, 8'h20, 0, 1, 32'hBEEF_AA44, 1, 0));
        tbl.push_back(mk(1, 0, 3'b010, 8'h10, 0, 1, 32'h8000_00FF, 1, 0));
        tbl.push_back(mk(0, 0, 3'b010, 8'h10, 0, 1, 32'h8000_00FF, 0, 0));

        foreach (tbl[i]) begin
            step(tbl[i].rd, tbl[i].wr, tbl[i].f3, tbl[i].addr, tbl[i].wd);
            if (tbl[i].chk_d) chk($sformatf("vec %0d data", i), rdata, tbl[i].ed);
            chk($sformatf("vec %0d valid", i), {31'h0, rvalid}, {31'h0, tbl[i].ev});
            chk($sformatf("vec %0d fault", i), {31'h0, fault}, {31'h0, tbl[i].ef});
        end

        // Small instance: top word written, word 0 untouched.
        s_step(0, 1, 3'b010, 5'h1C, 32'hCAFE_F00D);
        s_step(1, 0, 3'b010, 5'h1C, 0);
        chk("small LW 0x1C", s_rdata, 32'hCAFE_F00D);
        chk("small LW valid", {31'h0, s_rvalid}, 32'h1);
        s_step(1, 0, 3'b010, 5'h00, 0);
        chk("small LW 0x00", s_rdata, 32'h0);
        s_step(0, 0, 3'b000, 5'h00, 0);

        // Reset coinciding with a load drops its strobe.
        @(negedge clk_dm);
        rst = 1'b1; rd = 1'b1; wr = 1'b0; f3 = 3'b010; addr = 8'h10;
        @(posedge clk_dm);
        #1;
        chk("rst drops valid", {31'h0, rvalid}, 32'h0);
        chk("rst clears data", rdata, 32'h0);
        chk("rst sets busy", {31'h0, busy}, 32'h1);
        @(negedge clk_dm);
        rst = 1'b0;
        wait_idle(n_m, strb);
        chk("busy after op reset", n_m, 64);

        for (int w = 0; w < 64; w++) step(0, 1, 3'b010, 8'(w * 4), 32'hA5A5_0000 | w);
        step(1, 0, 3'b010, 8'h2C, 0);
        chk("fill readback", rdata, 32'hA5A5_000B);

        // Second clear, interrupted at counter 10, with requests held during busy.
        @(negedge clk_dm);
        rst = 1'b1; rd = 1'b0; wr = 1'b0;
        @(negedge clk_dm);
        rst = 1'b0; rd = 1'b1; wr = 1'b1; f3 = 3'b010; addr = 8'h2C;
        repeat (10) @(negedge clk_dm);
        rst = 1'b1;
        @(negedge clk_dm);
        rst = 1'b0;
        wait_idle(n_m, strb);
        chk("busy after mid-clear reset", n_m, 64);
        chk("strobes while busy", strb, 0);

        for (int w = 0; w < 64; w++) begin
            step(1, 0, 3'b010, 8'(w * 4), 32'h0);
            chk($sformatf("recleared LW %0d", w), rdata, 32'h0);
        end
        step(0, 0, 3'b010, 8'h0, 32'h0);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_miss);
        $finish;
    end
endmodule
